// File: rtl/sm_product_accumulator_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sm_product_accumulator_if : product-in / frame-sum-out handshake bus  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface sm_product_accumulator_if #(
    parameter int PW = 16,
    parameter int AW = 24
) ();
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] acc_out;
    logic          out_ovf;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out,
        output out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/sm_product_accumulator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sm_product_accumulator : sign-magnitude product -> saturating frame sum|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sm_product_accumulator #(
    parameter int PW  = 16,
    parameter int LEN = 8,
    parameter int AW  = 24
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    sm_product_accumulator_if.slave bus
);
    localparam int              c_cnt_w = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(LEN - 1);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [AW-1:0]       r_acc;
    logic                r_ovf;

    logic                w_accept;
    logic                w_last;
    logic                w_release;
    logic [AW-1:0]       w_mag;
    logic [AW-1:0]       w_value;
    logic [AW:0]         w_sum;
    logic                w_sat;
    logic [AW-1:0]       w_acc_nxt;

    assign bus.in_ready  = (r_state == ACC);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.acc_out   = r_acc;
    assign bus.out_ovf   = r_ovf;

    assign w_accept  = bus.in_valid && (r_state == ACC);
    assign w_last    = (r_cnt == c_last);
    assign w_release = (r_state == HOLD) && bus.out_ready;

    // Negative zero falls out naturally: -0 == 0.
    assign w_mag   = {{(AW-PW+1){1'b0}}, bus.in_data[PW-2:0]};
    assign w_value = bus.in_data[PW-1] ? (~w_mag + 1'b1) : w_mag;

    // One guard bit: the top two bits disagree exactly when the sum left AW-bit range.
    assign w_sum = {r_acc[AW-1], r_acc} + {w_value[AW-1], w_value};
    assign w_sat = (w_sum[AW] != w_sum[AW-1]);

    always_comb begin
        w_acc_nxt = w_sum[AW-1:0];
        if (w_sat) begin
            w_acc_nxt = w_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ACC;
        end else begin
            case (r_state)
                ACC:     if (w_accept && w_last) w_state_nxt = HOLD;
                HOLD:    if (bus.out_ready)      w_state_nxt = ACC;
                default: w_state_nxt = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_release) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | w_sat;
            r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sm_product_accumulator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sm_product_accumulator : scoreboard bench, LEN=4 / AW=16 build     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sm_product_accumulator;
    localparam int PW  = 16;
    localparam int LEN = 4;
    localparam int AW  = 16;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    always #5 clk = ~clk;

    sm_product_accumulator_if #(.PW(PW), .AW(AW)) bus ();

    sm_product_accumulator #(.PW(PW), .LEN(LEN), .AW(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] sum;
        logic          ovf;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_frames = 0;
    bit     rand_ready = 1'b0;

    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    int     m_cnt = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic [PW-1:0] d);
        longint mag;
        longint s;
        exp_t   e;
        mag = longint'(d[PW-2:0]);
        s   = d[PW-1] ? (m_acc - mag) : (m_acc + mag);
        if (s > 32767) begin
            m_acc = 32767;
            m_ovf = 1'b1;
        end else if (s < -32768) begin
            m_acc = -32768;
            m_ovf = 1'b1;
        end else begin
            m_acc = s;
        end
        m_cnt++;
        if (m_cnt == LEN) begin
            e.sum = m_acc[AW-1:0];
            e.ovf = m_ovf;
            q.push_back(e);
            model_reset();
        end
    endtask

    // Scoreboard: accepts feed the model, result handshakes are popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                q.delete();
            end else if (clr) begin
                if (bus.out_valid && q.size() > 0) void'(q.pop_front());
                model_reset();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    check_eq("result_pending", longint'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check_eq("frame_sum", bus.acc_out, e.sum);
                        check_eq("frame_ovf", bus.out_ovf, e.ovf);
                        n_frames++;
                    end
                end
                if (bus.in_valid && bus.in_ready) model_accept(bus.in_data);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] d);
        logic accepted;
        accepted    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 64; k++) begin
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            accepted = bus.in_ready;
            cycle();
            if (accepted) break;
        end
        bus.in_valid = 1'b0;
        check_eq("send_accepted", accepted, 1);
    endtask

    initial begin
        logic [PW-1:0] d;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        #2;
        check_eq("rst_in_ready",  bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_acc_out",   bus.acc_out, 0);
        check_eq("rst_out_ovf",   bus.out_ovf, 0);
        cycle();
        rst = 1'b0;
        cycle();

        // Basic frame: 3 - 5 + 10 - 0 = 8
        send(16'h0003);
        check_eq("basic_partial", bus.acc_out, 3);
        send(16'h8005);
        send(16'h000A);
        send(16'h8000);
        check_eq("basic_out_valid", bus.out_valid, 1);
        check_eq("basic_in_ready",  bus.in_ready, 0);
        check_eq("basic_sum",       bus.acc_out, 8);
        check_eq("basic_ovf",       bus.out_ovf, 0);
        cycle();
        check_eq("basic_after_valid", bus.out_valid, 0);
        check_eq("basic_after_ready", bus.in_ready, 1);
        check_eq("basic_after_acc",   bus.acc_out, 0);

        // Positive then negative saturation
        repeat (2) send(16'h3F01);
        check_eq("sat_pre_ovf", bus.out_ovf, 0);
        send(16'h3F01);
        check_eq("sat_pos_mid_acc", bus.acc_out, 16'h7FFF);
        check_eq("sat_pos_mid_ovf", bus.out_ovf, 1);
        send(16'h3F01);
        check_eq("sat_pos_acc", bus.acc_out, 16'h7FFF);
        check_eq("sat_pos_ovf", bus.out_ovf, 1);
        cycle();
        check_eq("sat_ovf_cleared", bus.out_ovf, 0);
        repeat (4) send(16'hBF01);
        check_eq("sat_neg_acc", bus.acc_out, 16'h8000);
        check_eq("sat_neg_ovf", bus.out_ovf, 1);
        cycle();

        // Backpressure: result held, inputs refused
        bus.out_ready = 1'b0;
        repeat (4) send(16'h0001);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_in_ready", bus.in_ready, 0);
            check_eq("bp_acc_hold", bus.acc_out, 4);
            cycle();
        end
        bus.out_ready = 1'b1;
        cycle();
        check_eq("bp_release_ready", bus.in_ready, 1);
        check_eq("bp_release_acc",   bus.acc_out, 0);
        cycle();
        bus.in_valid = 1'b0;
        check_eq("bp_first_accept", bus.acc_out, 1);
        repeat (3) send(16'h0001);
        cycle();

        // clr mid-frame with a simultaneous accept
        repeat (2) send(16'h0002);
        check_eq("clr_pre_acc", bus.acc_out, 4);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0007;
        cycle();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("clr_acc",      bus.acc_out, 0);
        check_eq("clr_in_ready", bus.in_ready, 1);
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        check_eq("clr_restart_not_done", bus.out_valid, 0);
        send(16'h0004);
        check_eq("clr_restart_sum", bus.acc_out, 10);
        cycle();

        // clr while a result is held drops it
        bus.out_ready = 1'b0;
        repeat (4) send(16'h0009);
        check_eq("clr_hold_valid", bus.out_valid, 1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check_eq("clr_hold_dropped", bus.out_valid, 0);
        check_eq("clr_hold_acc",     bus.acc_out, 0);
        bus.out_ready = 1'b1;

        // Asynchronous reset mid-frame, between clock edges
        repeat (3) send(16'h0005);
        check_eq("arst_pre_acc", bus.acc_out, 15);
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_acc",       bus.acc_out, 0);
        check_eq("arst_out_valid", bus.out_valid, 0);
        check_eq("arst_in_ready",  bus.in_ready, 1);
        check_eq("arst_out_ovf",   bus.out_ovf, 0);
        cycle();
        rst = 1'b0;
        repeat (4) send(16'h0001);
        cycle();

        // Random stream with input gaps and consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                cycle();
            end
            if ($urandom_range(0, 1) == 1)
                d = 16'($urandom_range(0, 65535));
            else
                d = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 300))};
            send(d);
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
        cycle();

        check_eq("queue_drained", q.size(), 0);
        check_eq("frames_seen",   n_frames, 7 + 1000 / LEN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
